// File: rtl/sig_debounce.sv
// rtl/sig_debounce.sv - synchroniser plus glitch filter with rise/fall strobes
// Optional rejected-glitch counter port enabled by SIG_DEBOUNCE_GLITCH_CNT_EN.
`timescale 1ns/1ps

module sig_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  output logic                dout,
  output logic                rise,
  output logic                fall,
  output logic                busy
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s != dout_q) begin
          cnt_d   = CW'(1);
          state_d = ST_CHECK;
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHECK: begin
        // Candidate fell back to the current level: discard it without touching dout.
        if (s == dout_q) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          dout_d  = s;
          rise_d  = s;
          fall_d  = ~s;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase
    busy_d = (state_d == ST_CHECK);
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
  logic                abort;
  logic [GLITCH_W-1:0] glitch_q;

  assign abort = (state_q == ST_CHECK) && (s == dout_q);

  // Saturating count; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_q <= glitch_q + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sig_debounce.sv
// tb/tb_sig_debounce.sv - scoreboard bench for sig_debounce
// Glitch counter checks are active when SIG_DEBOUNCE_GLITCH_CNT_EN is defined.
`timescale 1ns/1ps

module tb_sig_debounce;

  localparam int SS = 2;
  localparam int SC = 4;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic dout, rise, fall, busy;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
  logic [GW-1:0] glitch_cnt;
`endif

  sig_debounce #(
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC),
    .GLITCH_W     (GW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #10 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  typedef struct {
    logic dout;
    logic rise;
    logic fall;
    logic busy;
    int   gc;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;

  // Reference: a level reaches dout once it has been seen, after the
  // synchroniser delay, for SC consecutive samples differing from dout.
  bit m_hist[$];
  int m_run;
  bit m_dout;
  int m_gc;

  always @(posedge clk) begin
    exp_t e;
    bit   s;
    cyc++;
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (!rst_n) begin
      m_hist = {};
      repeat (SS) m_hist.push_front(1'b0);
      m_run  = 0;
      m_dout = 1'b0;
      m_gc   = 0;
    end else begin
      s = m_hist[SS-1];
      m_hist.push_front(din);
      void'(m_hist.pop_back());
      if (s != m_dout) begin
        m_run++;
        if (m_run == SC) begin
          m_dout = s;
          e.rise = s;
          e.fall = !s;
          m_run  = 0;
        end
      end else begin
        if (m_run > 0 && m_gc < (1 << GW) - 1) m_gc++;
        m_run = 0;
      end
    end
    e.dout = m_dout;
    e.busy = (m_run > 0);
    e.gc   = m_gc;
    expq.push_back(e);
  end

  int rise_n = 0;
  int fall_n = 0;
  int last_rise_cyc = 0;
  bit busy_seen = 0;

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      chk("dout", dout, e.dout);
      chk("rise", rise, e.rise);
      chk("fall", fall, e.fall);
      chk("busy", busy, e.busy);
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
      chk("glitch_cnt", glitch_cnt, e.gc);
`endif
    end
    if (rise) begin
      rise_n++;
      last_rise_cyc = cyc;
    end
    if (fall) fall_n++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  initial begin
    int c0, r0, f0;

    // 1: reset held with din toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3 din = ~din;
      @(posedge clk); #3 din = ~din;
    end
    chk("t1_dout", dout, 0);
    chk("t1_busy", busy, 0);
    @(negedge clk); #3;
    din = 1'b0;
    rst_n = 1'b1;
    cycles(10);

    // 2: clean rise, dout 6 edges later
    r0 = rise_n; f0 = fall_n;
    din = 1'b1;
    c0 = cyc;
    cycles(10);
    chk("t2_rise_count", rise_n - r0, 1);
    chk("t2_latency", last_rise_cyc - c0, 6);
    chk("t2_no_fall", fall_n - f0, 0);
    chk("t2_dout", dout, 1);
    din = 1'b0;
    cycles(10);
    chk("t2_fall_back", fall_n - f0, 1);

    // 3: 2.5-cycle glitch on idle line
    r0 = rise_n; f0 = fall_n; busy_seen = 0;
    din = 1'b1; #50; din = 1'b0;
    cycles(10);
    chk("t3_no_rise", rise_n - r0, 0);
    chk("t3_no_fall", fall_n - f0, 0);
    chk("t3_dout", dout, 0);
    chk("t3_busy_seen", busy_seen, 1);
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    chk("t3_glitch_cnt", glitch_cnt, 1);
`endif

    // 4: 80 ns high, 50 ns low, then high
    r0 = rise_n; f0 = fall_n;
    din = 1'b1; #80; din = 1'b0; #50; din = 1'b1;
    cycles(12);
    chk("t4_rise_count", rise_n - r0, 1);
    chk("t4_no_fall", fall_n - f0, 0);
    chk("t4_dout", dout, 1);
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    chk("t4_glitch_cnt", glitch_cnt, 2);
`endif
    din = 1'b0;
    cycles(10);

    // 5: async reset mid-qualification
    din = 1'b1;
    cycles(3);
    chk("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_dout_rst", dout, 0);
    chk("t5_busy_rst", busy, 0);
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    chk("t5_glitch_rst", glitch_cnt, 0);
`endif
    cycles(2);
    rst_n = 1'b1;
    c0 = cyc;
    cycles(8);
    chk("t5_latency", last_rise_cyc - c0, 6);
    chk("t5_dout", dout, 1);
    din = 1'b0;
    cycles(10);

    // 6: five glitches saturate the 2-bit counter
    r0 = rise_n;
    for (int i = 0; i < 5; i++) begin
      din = 1'b1; #50; din = 1'b0;
      cycles(8);
    end
    chk("t6_no_rise", rise_n - r0, 0);
    chk("t6_dout", dout, 0);
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    chk("t6_glitch_sat", glitch_cnt, 3);
`endif

    // random hold lengths around the qualification threshold
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #($urandom_range(1, 8));
      din = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    cycles(12);
    chk("scoreboard_drained", expq.size() <= 1, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
